// File: rtl/matmul_pkg.sv
// Shared state encoding and default sizing for the matmul engine arbiter.
package matmul_pkg;

  localparam int DEF_COL_BITS = 4;
  localparam int DEF_TIMEOUT  = 1024;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    READOUT,
    DONE
  } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin picker: combinational grant, last-winner pointer updated on 'update'.
// A lone requester always wins; on contention the one not granted last wins.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  // 1 means requester 1 won last, so requester 0 is favoured next.
  logic r_last;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = r_last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (update && (grant != 2'b00)) begin
      r_last <= grant[1];
    end
  end

endmodule

// File: rtl/matmul_arbiter.sv
// Shares one matmul engine between two requesters: start, wait for ready low/high, stream
// 2**COL_BITS results (1-cycle latency from mm_sel), abort with err after TIMEOUT wait cycles.
module matmul_arbiter
  import matmul_pkg::*;
#(
  parameter int COL_BITS = DEF_COL_BITS,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req,
  input  logic signed [15:0]  req0_data1,
  input  logic signed [15:0]  req0_data2,
  input  logic signed [15:0]  req1_data1,
  input  logic signed [15:0]  req1_data2,
  output logic [1:0]          grant,
  output logic                mm_start,
  input  logic                mm_ready,
  output logic signed [15:0]  mm_data1,
  output logic signed [15:0]  mm_data2,
  output logic [COL_BITS-1:0] mm_sel,
  input  logic [15:0]         mm_data_out,
  output logic                out_valid,
  output logic [COL_BITS-1:0] out_idx,
  output logic [15:0]         out_data,
  output logic                done,
  output logic                err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_grant;
  logic [1:0]          w_rr_grant;
  logic                w_rr_update;
  logic                w_abort;
  logic                w_tmo;
  logic [COL_BITS-1:0] r_idx;
  logic [TW-1:0]       r_tcnt;
  logic                r_out_valid;
  logic [COL_BITS-1:0] r_out_idx;
  logic [15:0]         r_out_data;
  logic                r_err;

  rr_arbiter_2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .update (w_rr_update),
    .grant  (w_rr_grant)
  );

  // Counter holds TIMEOUT-1 on the last permitted wait cycle; err lands as the count reaches TIMEOUT.
  assign w_tmo = (r_tcnt == TW'(TIMEOUT - 1));

  always_comb begin
    w_next      = r_state;
    w_rr_update = 1'b0;
    w_abort     = 1'b0;
    mm_start    = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (req != 2'b00) begin
          w_rr_update = 1'b1;
          w_next      = START;
        end
      end
      START: begin
        mm_start = 1'b1;
        w_next   = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (w_tmo) begin
          w_abort = 1'b1;
          w_next  = IDLE;
        end else if (!mm_ready) begin
          w_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (w_tmo) begin
          w_abort = 1'b1;
          w_next  = IDLE;
        end else if (mm_ready) begin
          w_next = READOUT;
        end
      end
      READOUT: begin
        if (r_idx == {COL_BITS{1'b1}}) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant     <= 2'b00;
      r_idx       <= '0;
      r_tcnt      <= '0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_err       <= w_abort;
      r_out_valid <= (r_state == READOUT);
      if (w_rr_update) begin
        r_grant <= w_rr_grant;
      end else if (w_abort || (r_state == DONE)) begin
        r_grant <= 2'b00;
      end
      if (r_state == START) begin
        r_tcnt <= '0;
      end else if ((r_state == WAIT_BUSY) || (r_state == WAIT_DONE)) begin
        r_tcnt <= r_tcnt + TW'(1);
      end
      // Index rests at 0 outside READOUT so the readout always begins at word 0.
      if (r_state == READOUT) begin
        r_idx      <= r_idx + COL_BITS'(1);
        r_out_idx  <= r_idx;
        r_out_data <= mm_data_out;
      end else begin
        r_idx <= '0;
      end
    end
  end

  assign grant     = r_grant;
  assign mm_sel    = (r_state == READOUT) ? r_idx : '0;
  assign out_valid = r_out_valid;
  assign out_idx   = r_out_idx;
  assign out_data  = r_out_data;
  assign err       = r_err;
  assign mm_data1  = r_grant[1] ? req1_data1 : (r_grant[0] ? req0_data1 : 16'sd0);
  assign mm_data2  = r_grant[1] ? req1_data2 : (r_grant[0] ? req0_data2 : 16'sd0);

endmodule

// File: tb/tb_matmul_arbiter.sv
// Directed bench for matmul_arbiter: default instance with a ready-dropping engine model,
// plus a TIMEOUT=8 instance whose engine never drops ready.
module tb_matmul_arbiter;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         req, req_t;
  logic signed [15:0] req0_data1, req0_data2, req1_data1, req1_data2;
  logic               mm_ready, mm_ready_t;
  logic [15:0]        mm_data_out;
  logic [7:0]         job_tag;

  logic [1:0]         grant, grant_t;
  logic               mm_start, mm_start_t;
  logic signed [15:0] mm_data1, mm_data2, mm_data1_t, mm_data2_t;
  logic [3:0]         mm_sel, mm_sel_t;
  logic               out_valid, out_valid_t;
  logic [3:0]         out_idx, out_idx_t;
  logic [15:0]        out_data, out_data_t;
  logic               done, done_t, err, err_t;

  int checks = 0;
  int errors = 0;

  int          ob_starts, ob_dones, ob_errs, ob_gchg;
  logic [1:0]  ob_grant;
  logic [15:0] ob_d1, ob_d2;
  logic        ob_done_valid;
  logic [3:0]  ob_done_idx;
  logic [3:0]  ob_idx[$];
  logic [15:0] ob_data[$];
  int          eng_cnt = 0;

  always #5 clk = ~clk;

  matmul_arbiter dut (
    .clk(clk), .rst(rst), .req(req),
    .req0_data1(req0_data1), .req0_data2(req0_data2),
    .req1_data1(req1_data1), .req1_data2(req1_data2),
    .grant(grant), .mm_start(mm_start), .mm_ready(mm_ready),
    .mm_data1(mm_data1), .mm_data2(mm_data2), .mm_sel(mm_sel),
    .mm_data_out(mm_data_out), .out_valid(out_valid), .out_idx(out_idx),
    .out_data(out_data), .done(done), .err(err)
  );

  matmul_arbiter #(.COL_BITS(4), .TIMEOUT(8)) dut_t (
    .clk(clk), .rst(rst), .req(req_t),
    .req0_data1(req0_data1), .req0_data2(req0_data2),
    .req1_data1(req1_data1), .req1_data2(req1_data2),
    .grant(grant_t), .mm_start(mm_start_t), .mm_ready(mm_ready_t),
    .mm_data1(mm_data1_t), .mm_data2(mm_data2_t), .mm_sel(mm_sel_t),
    .mm_data_out(mm_data_out), .out_valid(out_valid_t), .out_idx(out_idx_t),
    .out_data(out_data_t), .done(done_t), .err(err_t)
  );

  // Engine result word: job tag, a fixed nibble, then the requested index.
  assign mm_data_out = {job_tag, 4'h5, mm_sel};

  // Engine drops ready the cycle after start and raises it 20 cycles later.
  always @(negedge clk) begin
    if (mm_start) begin
      eng_cnt = 1;
    end else if (eng_cnt != 0) begin
      eng_cnt = eng_cnt + 1;
      if (eng_cnt == 2) mm_ready = 1'b0;
      if (eng_cnt == 22) begin
        mm_ready = 1'b1;
        eng_cnt  = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Records one job from the current negedge until done or budget expiry.
  task automatic observe(input int budget, input int drop_at, input bit drop_on_done);
    int start_c;
    ob_starts = 0; ob_dones = 0; ob_errs = 0; ob_gchg = 0;
    ob_grant = 2'bxx; ob_d1 = 'x; ob_d2 = 'x; ob_done_valid = 1'bx; ob_done_idx = 'x;
    ob_idx.delete(); ob_data.delete();
    start_c = 0;
    for (int c = 0; c < budget; c++) begin
      if (mm_start) begin
        ob_starts++; ob_grant = grant; start_c = c; ob_d1 = mm_data1; ob_d2 = mm_data2;
      end else if (ob_starts > 0 && grant !== ob_grant) begin
        ob_gchg++;
      end
      if (out_valid) begin
        ob_idx.push_back(out_idx);
        ob_data.push_back(out_data);
      end
      if (err) ob_errs++;
      if (drop_at >= 0 && ob_starts > 0 && c == start_c + drop_at) req = 2'b00;
      if (done) begin
        ob_dones++; ob_done_valid = out_valid; ob_done_idx = out_idx;
        if (drop_on_done) req = 2'b00;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b00; req_t = 2'b00; mm_ready = 1'b1; mm_ready_t = 1'b1;
    job_tag = 8'h00;
    req0_data1 = 16'sh7FFF; req0_data2 = 16'sh1234;
    req1_data1 = 16'sh0100; req1_data2 = 16'sh8001;
    repeat (3) @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant); end
    checks++; if (mm_start !== 1'b0) begin errors++; $display("FAIL reset_mm_start: got %b expected 0", mm_start); end
    checks++; if (mm_sel !== 4'd0) begin errors++; $display("FAIL reset_mm_sel: got %0d expected 0", mm_sel); end
    checks++; if (out_valid !== 1'b0 || out_idx !== 4'd0 || out_data !== 16'h0) begin
      errors++; $display("FAIL reset_out: got v=%b idx=%0d d=%h expected 0/0/0000", out_valid, out_idx, out_data);
    end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_done_err: got %b%b expected 00", done, err); end
    checks++; if (mm_data1 !== 16'h0) begin errors++; $display("FAIL reset_mm_data1: got %h expected 0000", mm_data1); end
    checks++; if (grant_t !== 2'b00 || err_t !== 1'b0) begin errors++; $display("FAIL reset_to_inst: got g=%b e=%b expected 00/0", grant_t, err_t); end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    repeat (2) @(negedge clk);
    job_tag = 8'h11; req = 2'b11;
    @(negedge clk);
    observe(200, -1, 1'b0);
    checks++; if (ob_grant !== 2'b01) begin errors++; $display("FAIL b2b_grant1: got %b expected 01", ob_grant); end
    checks++; if (ob_dones !== 1 || ob_idx.size() !== 16) begin
      errors++; $display("FAIL b2b_job1: got dones=%0d results=%0d expected 1/16", ob_dones, ob_idx.size());
    end
    @(negedge clk);
    checks++; if (grant !== 2'b00 || mm_start !== 1'b0) begin
      errors++; $display("FAIL b2b_idle_gap: got grant=%b start=%b expected 00/0", grant, mm_start);
    end
    job_tag = 8'h22;
    @(negedge clk);
    checks++; if (mm_start !== 1'b1) begin errors++; $display("FAIL b2b_second_start: got %b expected 1", mm_start); end
    observe(200, -1, 1'b1);
    checks++; if (ob_grant !== 2'b10) begin errors++; $display("FAIL b2b_grant2: got %b expected 10", ob_grant); end
    checks++; if (ob_dones !== 1 || ob_idx.size() !== 16) begin
      errors++; $display("FAIL b2b_job2: got dones=%0d results=%0d expected 1/16", ob_dones, ob_idx.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        logic [3:0] ei;
        ei = 4'(i);
        checks++;
        if (ob_idx[i] !== ei || ob_data[i] !== {8'h22, 4'h5, ei}) begin
          errors++; $display("FAIL b2b_result%0d: got idx=%0d d=%h expected idx=%0d d=%h", i, ob_idx[i], ob_data[i], ei, {8'h22, 4'h5, ei});
        end
      end
    end
  endtask

  task automatic test_single_job();
    repeat (2) @(negedge clk);
    job_tag = 8'h3C; req = 2'b01;
    @(negedge clk);
    observe(200, -1, 1'b1);
    checks++; if (ob_starts !== 1) begin errors++; $display("FAIL single_starts: got %0d expected 1", ob_starts); end
    checks++; if (ob_grant !== 2'b01 || ob_gchg !== 0) begin
      errors++; $display("FAIL single_grant: got %b changes=%0d expected 01/0", ob_grant, ob_gchg);
    end
    checks++; if (ob_d1 !== 16'h7FFF || ob_d2 !== 16'h1234) begin
      errors++; $display("FAIL single_operands: got %h %h expected 7fff 1234", ob_d1, ob_d2);
    end
    checks++; if (ob_dones !== 1 || ob_done_valid !== 1'b1 || ob_done_idx !== 4'd15) begin
      errors++; $display("FAIL single_done: got dones=%0d v=%b idx=%0d expected 1/1/15", ob_dones, ob_done_valid, ob_done_idx);
    end
    checks++; if (ob_errs !== 0) begin errors++; $display("FAIL single_err: got %0d expected 0", ob_errs); end
    checks++; if (ob_idx.size() !== 16) begin
      errors++; $display("FAIL single_count: got %0d expected 16", ob_idx.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        logic [3:0] ei;
        ei = 4'(i);
        checks++;
        if (ob_idx[i] !== ei || ob_data[i] !== {8'h3C, 4'h5, ei}) begin
          errors++; $display("FAIL single_result%0d: got idx=%0d d=%h expected idx=%0d d=%h", i, ob_idx[i], ob_data[i], ei, {8'h3C, 4'h5, ei});
        end
      end
    end
  endtask

  task automatic test_req_drop();
    repeat (2) @(negedge clk);
    job_tag = 8'h5A; req = 2'b01;
    @(negedge clk);
    observe(200, 5, 1'b1);
    checks++; if (ob_dones !== 1 || ob_idx.size() !== 16) begin
      errors++; $display("FAIL drop_complete: got dones=%0d results=%0d expected 1/16", ob_dones, ob_idx.size());
    end
    checks++; if (ob_grant !== 2'b01 || ob_gchg !== 0) begin
      errors++; $display("FAIL drop_grant_hold: got %b changes=%0d expected 01/0", ob_grant, ob_gchg);
    end
  endtask

  task automatic test_timeout();
    int err_cnt, err_k, n_valid, n_done, n_start;
    logic [1:0] g_err, g_pre;
    err_cnt = 0; err_k = -1; n_valid = 0; n_done = 0; n_start = 0; g_err = 2'bxx; g_pre = 2'bxx;
    repeat (2) @(negedge clk);
    req_t = 2'b01;
    @(negedge clk);
    checks++; if (mm_start_t !== 1'b1 || grant_t !== 2'b01) begin
      errors++; $display("FAIL to_start: got start=%b grant=%b expected 1/01", mm_start_t, grant_t);
    end
    req_t = 2'b00;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (mm_start_t) n_start++;
      if (out_valid_t) n_valid++;
      if (done_t) n_done++;
      if (k == 8) g_pre = grant_t;
      if (err_t) begin err_cnt++; err_k = k; g_err = grant_t; end
    end
    checks++; if (err_cnt !== 1 || err_k !== 9) begin
      errors++; $display("FAIL to_err_pulse: got count=%0d at=%0d expected 1 at 9", err_cnt, err_k);
    end
    checks++; if (g_pre !== 2'b01 || g_err !== 2'b00) begin
      errors++; $display("FAIL to_grant: got before=%b at_err=%b expected 01/00", g_pre, g_err);
    end
    checks++; if (n_valid !== 0 || n_done !== 0 || n_start !== 0) begin
      errors++; $display("FAIL to_quiet: got valid=%0d done=%0d start=%0d expected 0/0/0", n_valid, n_done, n_start);
    end
  endtask

  task automatic test_reset_mid_readout();
    bit found;
    found = 1'b0;
    repeat (2) @(negedge clk);
    job_tag = 8'h77; req = 2'b01;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (mm_sel === 4'd5) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL rstmid_reach_idx5: got not found expected found"); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (grant !== 2'b00 || mm_start !== 1'b0 || mm_sel !== 4'd0) begin
      errors++; $display("FAIL rstmid_ctrl: got g=%b s=%b sel=%0d expected 00/0/0", grant, mm_start, mm_sel);
    end
    checks++; if (out_valid !== 1'b0 || out_idx !== 4'd0 || out_data !== 16'h0 || done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL rstmid_out: got v=%b idx=%0d d=%h done=%b err=%b expected all 0", out_valid, out_idx, out_data, done, err);
    end
    rst = 1'b0; req = 2'b10; job_tag = 8'h99;
    @(negedge clk);
    observe(200, -1, 1'b1);
    checks++; if (ob_starts !== 1 || ob_grant !== 2'b10) begin
      errors++; $display("FAIL rstmid_next_grant: got starts=%0d grant=%b expected 1/10", ob_starts, ob_grant);
    end
    checks++; if (ob_dones !== 1 || ob_idx.size() !== 16 || ob_done_idx !== 4'd15) begin
      errors++; $display("FAIL rstmid_next_job: got dones=%0d results=%0d last=%0d expected 1/16/15", ob_dones, ob_idx.size(), ob_done_idx);
    end
  endtask

  task automatic test_operand_mux();
    repeat (2) @(negedge clk);
    req = 2'b10;
    @(negedge clk);
    req = 2'b00;
    #1;
    checks++; if (grant !== 2'b10 || mm_data1 !== 16'h0100 || mm_data2 !== 16'h8001) begin
      errors++; $display("FAIL mux_grant10: got g=%b d1=%h d2=%h expected 10/0100/8001", grant, mm_data1, mm_data2);
    end
    observe(200, -1, 1'b1);
    @(negedge clk);
    checks++; if (grant !== 2'b00 || mm_data1 !== 16'h0 || mm_data2 !== 16'h0) begin
      errors++; $display("FAIL mux_idle_zero: got g=%b d1=%h d2=%h expected 00/0000/0000", grant, mm_data1, mm_data2);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single_job();
    test_req_drop();
    test_timeout();
    test_reset_mid_readout();
    test_operand_mux();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
